// File: rtl/heartbeat_monitor.sv
`default_nettype none
// ============================================================================
// Module   : heartbeat_monitor
// Brief    : Receive-side heartbeat checker. Synchronises a pad input, measures
//            the toggle-to-toggle distance and tracks lock / loss of the beat.
// Revision : 1.0 - initial release
// ============================================================================
module heartbeat_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PERIOD  = 4,
    parameter int MAX_PERIOD  = 20,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_Y,
    output logic             sig_A,
    output logic             sig_OE,
    output logic             sig_IE,
    output logic             sig_SL,
    output logic             sig_CS,
    output logic             sig_PD,
    output logic             sig_PU,
    output logic             edge_stb,
    output logic [CNT_W-1:0] interval,
    output logic             interval_vld,
    output logic [CNT_W-1:0] edge_count,
    output logic             locked,
    output logic             lost
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_acquire = 2'd1;
    localparam logic [1:0] c_st_locked  = 2'd2;
    localparam logic [1:0] c_st_lost    = 2'd3;

    localparam logic [CNT_W-1:0] c_max_cnt  = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] c_sat_cnt  = CNT_W'(MAX_PERIOD + 1);
    localparam logic [CNT_W:0]   c_min_dist = (CNT_W+1)'(MIN_PERIOD);
    localparam logic [CNT_W:0]   c_max_dist = (CNT_W+1)'(MAX_PERIOD);
    localparam logic [3:0]       c_lock_n   = 4'(LOCK_COUNT);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_edge_stb;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_interval;
    logic                   r_interval_vld;
    logic [CNT_W-1:0]       r_edge_count;
    logic [1:0]             r_state;
    logic [3:0]             r_good;
    logic                   r_locked;
    logic                   r_lost;

    logic                   w_s;
    logic                   w_edge;
    logic [CNT_W:0]         w_dist;
    logic                   w_legal;
    logic                   w_timeout;
    logic [3:0]             w_good_inc;
    logic [1:0]             w_state_nxt;
    logic [3:0]             w_good_nxt;
    logic                   w_lost_nxt;
    logic                   w_vld_nxt;

    // Pad is used purely as an input.
    assign sig_A  = 1'b0;
    assign sig_OE = 1'b0;
    assign sig_IE = 1'b1;
    assign sig_SL = 1'b0;
    assign sig_CS = 1'b0;
    assign sig_PD = 1'b0;
    assign sig_PU = 1'b0;

    // The edge decision is made one cycle before edge_stb is visible so that the
    // strobe, the interval and the state update all appear in the same cycle.
    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_edge     = w_s ^ r_prev;
    // r_cnt holds distance-1 from the last strobe at the moment of the decision.
    assign w_dist     = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_legal    = (w_dist >= c_min_dist) && (w_dist <= c_max_dist);
    // Fires once: the counter moves on to its saturation value right after.
    assign w_timeout  = !w_edge && (r_cnt == c_max_cnt);
    assign w_good_inc = r_good + 4'd1;

    // Synchroniser, edge detector and saturating distance counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync       <= '0;
            r_prev       <= 1'b0;
            r_edge_stb   <= 1'b0;
            r_cnt        <= '0;
            r_edge_count <= '0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], sig_Y};
            r_prev     <= w_s;
            r_edge_stb <= w_edge;
            if (w_edge) begin
                r_cnt        <= '0;
                r_edge_count <= r_edge_count + CNT_W'(1);
            end else if (r_cnt != c_sat_cnt) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Lock FSM state, legal-interval count and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= c_st_idle;
            r_good         <= '0;
            r_locked       <= 1'b0;
            r_lost         <= 1'b0;
            r_interval_vld <= 1'b0;
            r_interval     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_good         <= w_good_nxt;
            r_locked       <= (w_state_nxt == c_st_locked);
            r_lost         <= w_lost_nxt;
            r_interval_vld <= w_vld_nxt;
            if (w_vld_nxt) begin
                r_interval <= w_dist[CNT_W-1:0];
            end
        end
    end

    // Next-state logic; the first edge after IDLE/LOST only restarts acquisition.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_lost_nxt  = 1'b0;
        w_vld_nxt   = 1'b0;
        case (r_state)
            c_st_idle, c_st_lost: begin
                if (w_edge) begin
                    w_state_nxt = c_st_acquire;
                    w_good_nxt  = '0;
                end
            end
            c_st_acquire: begin
                if (w_edge) begin
                    w_vld_nxt = 1'b1;
                    if (w_legal) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == c_lock_n) begin
                            w_state_nxt = c_st_locked;
                        end
                    end else begin
                        w_good_nxt = '0;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_locked: begin
                if (w_edge) begin
                    w_vld_nxt = 1'b1;
                    if (!w_legal) begin
                        w_state_nxt = c_st_lost;
                        w_lost_nxt  = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = c_st_lost;
                    w_lost_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign edge_stb     = r_edge_stb;
    assign interval     = r_interval;
    assign interval_vld = r_interval_vld;
    assign edge_count   = r_edge_count;
    assign locked       = r_locked;
    assign lost         = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_heartbeat_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_heartbeat_monitor
// Brief    : Self-checking bench for heartbeat_monitor: scenario table, corner
//            sequences and random toggling against a timestamp-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_heartbeat_monitor;

    localparam int CNT_W  = 16;
    localparam int MIN_P  = 4;
    localparam int MAX_P  = 20;
    localparam int LOCK_N = 4;

    localparam int M_IDLE = 0;
    localparam int M_ACQ  = 1;
    localparam int M_LOCK = 2;
    localparam int M_LOST = 3;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             sig_Y = 1'b0;
    logic             sig_A, sig_OE, sig_IE, sig_SL, sig_CS, sig_PD, sig_PU;
    logic             edge_stb, interval_vld, locked, lost;
    logic [CNT_W-1:0] interval, edge_count;

    int n_checks = 0;
    int n_fail   = 0;

    heartbeat_monitor #(
        .CNT_W(CNT_W), .SYNC_STAGES(2), .MIN_PERIOD(MIN_P),
        .MAX_PERIOD(MAX_P), .LOCK_COUNT(LOCK_N)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sig_Y(sig_Y),
        .sig_A(sig_A), .sig_OE(sig_OE), .sig_IE(sig_IE), .sig_SL(sig_SL),
        .sig_CS(sig_CS), .sig_PD(sig_PD), .sig_PU(sig_PU),
        .edge_stb(edge_stb), .interval(interval), .interval_vld(interval_vld),
        .edge_count(edge_count), .locked(locked), .lost(lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pad toggles show up as strobes three cycles later; lock
    // status follows from timestamps of those strobes.
    logic             m_y1, m_y2, m_y3;
    logic             m_edge, m_vld, m_lost, m_locked, m_valid;
    logic [CNT_W-1:0] m_interval, m_count;
    int               m_state, m_good, m_last, m_cyc, m_d;

    initial begin
        m_valid = 1'b0;
        m_cyc   = 0;
    end

    always @(posedge clk) begin
        m_cyc   = m_cyc + 1;
        m_valid = 1'b1;
        if (!rst_n) begin
            {m_y1, m_y2, m_y3} = 3'b000;
            {m_edge, m_vld, m_lost, m_locked} = 4'b0000;
            m_interval = '0;
            m_count    = '0;
            m_state    = M_IDLE;
            m_good     = 0;
            m_last     = m_cyc;
        end else begin
            m_edge = m_y2 ^ m_y3;
            m_vld  = 1'b0;
            m_lost = 1'b0;
            m_d    = m_cyc - m_last;
            if (m_edge) begin
                m_count = m_count + 1'b1;
                if (m_state == M_IDLE || m_state == M_LOST) begin
                    m_state = M_ACQ;
                    m_good  = 0;
                end else begin
                    m_interval = CNT_W'(m_d);
                    m_vld      = 1'b1;
                    if (m_d >= MIN_P && m_d <= MAX_P) begin
                        if (m_state == M_ACQ) begin
                            m_good = m_good + 1;
                            if (m_good == LOCK_N) m_state = M_LOCK;
                        end
                    end else if (m_state == M_ACQ) begin
                        m_good = 0;
                    end else begin
                        m_state = M_LOST;
                        m_lost  = 1'b1;
                    end
                end
                m_last = m_cyc;
            end else if (m_d == MAX_P + 1) begin
                if (m_state == M_ACQ) begin
                    m_state = M_IDLE;
                end else if (m_state == M_LOCK) begin
                    m_state = M_LOST;
                    m_lost  = 1'b1;
                end
            end
            m_locked = (m_state == M_LOCK);
            m_y3 = m_y2;
            m_y2 = m_y1;
            m_y1 = sig_Y;
        end
    end

    // Continuous comparison of every output against the model, mid-cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_edge_stb", 32'(edge_stb), 32'(m_edge));
            chk("model_interval", 32'(interval), 32'(m_interval));
            chk("model_interval_vld", 32'(interval_vld), 32'(m_vld));
            chk("model_edge_count", 32'(edge_count), 32'(m_count));
            chk("model_locked", 32'(locked), 32'(m_locked));
            chk("model_lost", 32'(lost), 32'(m_lost));
            chk("pad_ties", 32'({sig_A, sig_OE, sig_IE, sig_SL, sig_CS, sig_PD, sig_PU}), 32'(7'b0010000));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sig_Y = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Toggle the pad n times, p cycles apart.
    task automatic toggles(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (p) @(negedge clk);
            sig_Y = ~sig_Y;
        end
    endtask

    typedef struct {
        int   period;
        int   n_tog;
        logic exp_locked;
        int   exp_interval;
    } vec_t;

    vec_t vecs[7];
    int   t_lost;

    initial begin
        vecs[0] = '{10, 5, 1'b1, 10};
        vecs[1] = '{10, 4, 1'b0, 10};
        vecs[2] = '{ 4, 5, 1'b1,  4};
        vecs[3] = '{20, 5, 1'b1, 20};
        vecs[4] = '{ 3, 8, 1'b0,  3};
        vecs[5] = '{21, 6, 1'b0, 21};
        vecs[6] = '{22, 5, 1'b0,  0};

        // Reset held with the pad toggling: nothing may get through.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sig_Y = ~sig_Y;
            chk("rst_edge_stb", 32'(edge_stb), 32'd0);
            chk("rst_locked", 32'(locked), 32'd0);
            chk("rst_edge_count", 32'(edge_count), 32'd0);
            chk("rst_sig_IE", 32'(sig_IE), 32'd1);
        end

        // Scenario table, each from a fresh reset.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            toggles(vecs[v].period, vecs[v].n_tog);
            repeat (4) @(negedge clk);
            chk($sformatf("tbl%0d_locked", v), 32'(locked), 32'(vecs[v].exp_locked));
            chk($sformatf("tbl%0d_interval", v), 32'(interval), 32'(vecs[v].exp_interval));
            chk($sformatf("tbl%0d_edge_count", v), 32'(edge_count), 32'(vecs[v].n_tog));
        end

        // Short interval during acquisition restarts the legal count.
        do_reset();
        toggles(10, 3);
        toggles(3, 1);
        toggles(10, 3);
        repeat (4) @(negedge clk);
        chk("acq_reset_not_locked", 32'(locked), 32'd0);
        toggles(6, 1);
        repeat (3) @(negedge clk);
        chk("acq_reset_relock", 32'(locked), 32'd1);

        // Timeout loss: lost arrives 3 + 21 cycles after the final pad toggle.
        do_reset();
        toggles(10, 5);
        t_lost = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (lost === 1'b1) begin
                t_lost = i;
                break;
            end
        end
        chk("timeout_lost_delay", 32'(t_lost), 32'd24);
        chk("timeout_locked", 32'(locked), 32'd0);
        @(negedge clk);
        chk("timeout_lost_single", 32'(lost), 32'd0);
        toggles(10, 5);
        repeat (3) @(negedge clk);
        chk("timeout_relock", 32'(locked), 32'd1);

        // Glitch loss: legal 5 then a 2-cycle pair.
        do_reset();
        toggles(10, 5);
        toggles(5, 1);
        toggles(2, 1);
        repeat (3) @(negedge clk);
        chk("glitch_edge_stb", 32'(edge_stb), 32'd1);
        chk("glitch_lost", 32'(lost), 32'd1);
        chk("glitch_interval", 32'(interval), 32'd2);
        @(negedge clk);
        chk("glitch_locked", 32'(locked), 32'd0);

        // One-cycle reset while locked.
        do_reset();
        toggles(10, 5);
        repeat (3) @(negedge clk);
        chk("midrst_pre_locked", 32'(locked), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_edge_count", 32'(edge_count), 32'd0);
        chk("midrst_lost", 32'(lost), 32'd0);
        toggles(10, 5);
        repeat (3) @(negedge clk);
        chk("midrst_relock", 32'(locked), 32'd1);

        // Random toggling, biased towards legal distances, with rare resets.
        for (int it = 0; it < 200; it++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            if (r < 14) toggles(int'($urandom_range(MIN_P, MAX_P)), 1);
            else        toggles(int'($urandom_range(1, MAX_P + 4)), 1);
        end
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
